// File: rtl/alu_seq.sv
// alu_seq: parametrised ALU for the bus-based computer.
// Seven single-cycle ops (ADD, SUB, ADC, SBC, AND, OR, XOR) computed
// combinationally from a, b, op and the carry flag, plus a multi-cycle
// shift-add unsigned multiply with a go/busy/done handshake.
// Ports:
//   clk, clr    - rising-edge clock, asynchronous active-high reset
//   a, b        - operands
//   op          - operation select (111 = MUL)
//   hi          - MUL only: select high half of the product for the bus
//   go          - start multiply (ignored while busy or when op != MUL)
//   out         - drive result onto the tri-state bus, else high-Z
//   fi          - load all four flags from the current op (ignored while busy)
//   bus         - tri-state result
//   carry, zero, neg, ovf - flag registers
//   busy, done  - multiply in progress / one-cycle completion pulse
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             hi,
  input  logic             go,
  input  logic             out,
  input  logic             fi,
  output tri   [WIDTH-1:0] bus,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_n;
  logic [WIDTH-1:0]  mcand_q, mcand_n;
  logic [WIDTH-1:0]  mplier_q, mplier_n;
  logic [PW-1:0]     prod_q, prod_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic              busy_n, done_n;
  logic              carry_n, zero_n, neg_n, ovf_n;

  logic [WIDTH-1:0]  bx;
  logic              cin;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  res;
  logic              c_int, z_int, n_int, v_int;
  logic [WIDTH:0]    step_sum;

  // Single-cycle datapath and internal flag values for the current op
  always_comb begin : alu_comb
    bx    = ((op == OP_SUB) || (op == OP_SBC)) ? ~b : b;
    cin   = 1'b0;
    case (op)
      OP_SUB:         cin = 1'b1;
      OP_ADC, OP_SBC: cin = carry;
      default:        cin = 1'b0;
    endcase
    sum   = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(cin);
    res   = sum[WIDTH-1:0];
    c_int = 1'b0;
    v_int = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        res   = sum[WIDTH-1:0];
        c_int = sum[WIDTH];
        v_int = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      default: begin
        res   = hi ? prod_q[PW-1:WIDTH] : prod_q[WIDTH-1:0];
        c_int = |prod_q[PW-1:WIDTH];
        v_int = |prod_q[PW-1:WIDTH];
      end
    endcase
    // MUL flags describe the whole product, not just the selected half
    z_int = (op == OP_MUL) ? ~|prod_q : ~|res;
    n_int = (op == OP_MUL) ? prod_q[WIDTH-1] : res[WIDTH-1];
  end

  assign bus = out ? res : {WIDTH{1'bz}};

  // State register and datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_n;
      mcand_q  <= mcand_n;
      mplier_q <= mplier_n;
      prod_q   <= prod_n;
      cnt_q    <= cnt_n;
      busy     <= busy_n;
      done     <= done_n;
      carry    <= carry_n;
      zero     <= zero_n;
      neg      <= neg_n;
      ovf      <= ovf_n;
    end
  end

  // Next-state: multiply sequencer and flag loading
  always_comb begin : fsm_comb
    state_n  = state_q;
    mcand_n  = mcand_q;
    mplier_n = mplier_q;
    prod_n   = prod_q;
    cnt_n    = cnt_q;
    busy_n   = busy;
    done_n   = 1'b0;
    carry_n  = carry;
    zero_n   = zero;
    neg_n    = neg;
    ovf_n    = ovf;

    // Conditional add of the multiplicand into the high half, keeping its carry
    step_sum = {1'b0, prod_q[PW-1:WIDTH]} + ({1'b0, mcand_q} & {(WIDTH+1){mplier_q[0]}});

    if (fi && !busy) begin
      carry_n = c_int;
      zero_n  = z_int;
      neg_n   = n_int;
      ovf_n   = v_int;
    end

    case (state_q)
      S_IDLE: begin
        if (go && (op == OP_MUL)) begin
          mcand_n  = a;
          mplier_n = b;
          prod_n   = '0;
          cnt_n    = CW'(WIDTH);
          busy_n   = 1'b1;
          state_n  = S_RUN;
        end
      end
      S_RUN: begin
        // {carry-out, high, low} shifted right by one
        prod_n   = {step_sum, prod_q[WIDTH-1:1]};
        mplier_n = mplier_q >> 1;
        cnt_n    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): scoreboard of expected results
// pushed when stimulus is driven, popped and compared when output is sampled.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [2:0]   op  = 3'b111;
  logic         hi  = 1'b0;
  logic         go  = 1'b0;
  logic         out = 1'b1;
  logic         fi  = 1'b0;
  wire  [W-1:0] bus;
  logic         carry, zero, neg, ovf, busy, done;

  // Weak pull-ups: a released bus reads all-ones
  for (genvar i = 0; i < W; i++) begin : g_pu
    pullup (bus[i]);
  end

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .a(a), .b(b), .op(op), .hi(hi), .go(go),
    .out(out), .fi(fi), .bus(bus), .carry(carry), .zero(zero),
    .neg(neg), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] fl;   // {carry, zero, neg, ovf}
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_fl   = 4'b0000;

  logic [2:0] t_op [9] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd2, 3'd6, 3'd3, 3'd4, 3'd5};
  logic [7:0] t_a  [9] = '{8'h7F, 8'h05, 8'h03, 8'hFF, 8'h01, 8'hF0, 8'h10, 8'hC3, 8'h0C};
  logic [7:0] t_b  [9] = '{8'h01, 8'h05, 8'h05, 8'h01, 8'h00, 8'hFF, 8'h01, 8'h5A, 8'h30};

  // Integer reference for single-cycle ops; carry means "no borrow" on subtract
  function automatic exp_t model_alu(input logic [2:0] o, input logic [7:0] x,
                                     input logic [7:0] y, input logic c);
    int s, ss, sx, sy, ci;
    logic cout, ov;
    logic [7:0] r;
    exp_t e;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ci = c ? 1 : 0;
    s = 0; ss = 0; cout = 1'b0;
    case (o)
      3'd0: begin s = int'(x) + int'(y);          ss = sx + sy;          cout = (s > 255); end
      3'd1: begin s = int'(x) - int'(y);          ss = sx - sy;          cout = (s >= 0);  end
      3'd2: begin s = int'(x) + int'(y) + ci;     ss = sx + sy + ci;     cout = (s > 255); end
      3'd3: begin s = int'(x) - int'(y) - 1 + ci; ss = sx - sy - 1 + ci; cout = (s >= 0);  end
      3'd4: s = int'(x & y);
      3'd5: s = int'(x | y);
      default: s = int'(x ^ y);
    endcase
    ov = (o <= 3'd3) && ((ss > 127) || (ss < -128));
    r  = 8'(s);
    e.lo = r;
    e.hi = 8'h00;
    e.fl = {cout, (r == 8'h00), r[7], ov};
    return e;
  endfunction

  function automatic exp_t model_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    exp_t e;
    p = 16'(x) * 16'(y);
    e.lo = p[7:0];
    e.hi = p[15:8];
    e.fl = {|p[15:8], (p == 16'h0000), p[7], |p[15:8]};
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if ({carry, zero, neg, ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {carry, zero, neg, ovf}); end
    hi = 1'b0; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL reset_prod_lo got %h want 00", bus); end
    hi = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL reset_prod_hi got %h want 00", bus); end
    hi = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    m_fl = 4'b0000;
  endtask

  task automatic test_single_cycle();
    exp_t e;
    logic [2:0] o;
    logic [7:0] x, y;
    for (int i = 0; i < 19; i++) begin
      if (i < 9) begin
        o = t_op[i]; x = t_a[i]; y = t_b[i];
      end else begin
        o = 3'($urandom_range(0, 6)); x = 8'($urandom); y = 8'($urandom);
      end
      op = o; a = x; b = y; out = 1'b1; fi = 1'b0;
      exp_q.push_back(model_alu(o, x, y, m_fl[3]));
      #1;
      e = exp_q.pop_front();
      checks++; if (bus !== e.lo) begin
        errors++; $display("FAIL alu_bus[%0d] op=%0d a=%h b=%h got %h want %h", i, o, x, y, bus, e.lo); end
      fi = 1'b1;
      cycle();
      fi = 1'b0;
      checks++; if ({carry, zero, neg, ovf} !== e.fl) begin
        errors++; $display("FAIL alu_flags[%0d] op=%0d a=%h b=%h got %b want %b",
                           i, o, x, y, {carry, zero, neg, ovf}, e.fl); end
      m_fl = e.fl;
    end
  endtask

  task automatic test_bus_release();
    exp_t e;
    op = 3'd0; a = 8'h7F; b = 8'h01; out = 1'b1;
    exp_q.push_back(model_alu(3'd0, 8'h7F, 8'h01, m_fl[3]));
    e = exp_q.pop_front();
    #1;
    checks++; if (bus !== e.lo) begin errors++; $display("FAIL bus_drive got %h want %h", bus, e.lo); end
    out = 1'b0; #1;
    checks++; if (bus !== 8'hFF) begin errors++; $display("FAIL bus_release got %h want FF(pulled)", bus); end
    out = 1'b1; #1;
    checks++; if (bus !== e.lo) begin errors++; $display("FAIL bus_redrive got %h want %h", bus, e.lo); end
  endtask

  task automatic test_mul(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int n;
    op = 3'd7; a = x; b = y; go = 1'b1; fi = 1'b0; out = 1'b1;
    cycle();
    go = 1'b0; a = ~x; b = 8'h5A;
    exp_q.push_back(model_mul(x, y));
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_start_busy got %b want 1", busy); end
    n = 1;
    while (busy === 1'b1 && n < 40) begin
      cycle();
      if (busy === 1'b1) n++;
    end
    checks++; if (n != W) begin errors++; $display("FAIL mul_busy_len %h*%h got %0d want %0d", x, y, n, W); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mul_done got %b want 1", done); end
    e = exp_q.pop_front();
    hi = 1'b0; #1;
    checks++; if (bus !== e.lo) begin errors++; $display("FAIL mul_lo %h*%h got %h want %h", x, y, bus, e.lo); end
    hi = 1'b1; #1;
    checks++; if (bus !== e.hi) begin errors++; $display("FAIL mul_hi %h*%h got %h want %h", x, y, bus, e.hi); end
    hi = 1'b0;
    fi = 1'b1;
    cycle();
    fi = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_width got %b want 0", done); end
    checks++; if ({carry, zero, neg, ovf} !== e.fl) begin
      errors++; $display("FAIL mul_flags %h*%h got %b want %b", x, y, {carry, zero, neg, ovf}, e.fl); end
    m_fl = e.fl;
  endtask

  task automatic test_interlock();
    exp_t e;
    int n;
    // Give the flags a known non-trivial value first
    op = 3'd0; a = 8'h7F; b = 8'h01; fi = 1'b1;
    e = model_alu(3'd0, 8'h7F, 8'h01, m_fl[3]);
    cycle();
    fi = 1'b0; m_fl = e.fl;
    op = 3'd7; a = 8'h03; b = 8'h05; go = 1'b1;
    cycle();
    go = 1'b0;
    exp_q.push_back(model_mul(8'h03, 8'h05));
    n = 1;
    while (busy === 1'b1 && n < 40) begin
      if (n == 2) begin go = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (n == 4) fi = 1'b1;
      cycle();
      go = 1'b0; fi = 1'b0;
      if (busy === 1'b1) n++;
    end
    checks++; if (n != W) begin errors++; $display("FAIL lock_busy_len got %0d want %0d", n, W); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL lock_done got %b want 1", done); end
    e = exp_q.pop_front();
    hi = 1'b0; #1;
    checks++; if (bus !== e.lo) begin errors++; $display("FAIL lock_lo got %h want %h", bus, e.lo); end
    hi = 1'b1; #1;
    checks++; if (bus !== e.hi) begin errors++; $display("FAIL lock_hi got %h want %h", bus, e.hi); end
    hi = 1'b0;
    checks++; if ({carry, zero, neg, ovf} !== m_fl) begin
      errors++; $display("FAIL lock_flags got %b want %b", {carry, zero, neg, ovf}, m_fl); end
    cycle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    op = 3'd7; a = 8'h0F; b = 8'h11; go = 1'b1; fi = 1'b0;
    cycle();
    exp_q.push_back(model_mul(8'h0F, 8'h11));
    a = 8'h12; b = 8'h34;   // go stays high through the completion edge
    n = 1;
    while (busy === 1'b1 && n < 40) begin
      cycle();
      if (busy === 1'b1) n++;
    end
    checks++; if (n != W) begin errors++; $display("FAIL b2b_busy_len got %0d want %0d", n, W); end
    checks++; if ({busy, done} !== 2'b01) begin
      errors++; $display("FAIL b2b_complete busy,done got %b want 01", {busy, done}); end
    e = exp_q.pop_front();
    hi = 1'b0; #1;
    checks++; if (bus !== e.lo) begin errors++; $display("FAIL b2b_lo1 got %h want %h", bus, e.lo); end
    hi = 1'b1; #1;
    checks++; if (bus !== e.hi) begin errors++; $display("FAIL b2b_hi1 got %h want %h", bus, e.hi); end
    hi = 1'b0;
    exp_q.push_back(model_mul(8'h12, 8'h34));
    fi = 1'b1;
    cycle();
    go = 1'b0; fi = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", busy); end
    checks++; if ({carry, zero, neg, ovf} !== e.fl) begin
      errors++; $display("FAIL b2b_flags1 got %b want %b", {carry, zero, neg, ovf}, e.fl); end
    m_fl = e.fl;
    n = 1;
    while (busy === 1'b1 && n < 40) begin
      cycle();
      if (busy === 1'b1) n++;
    end
    checks++; if (n != W) begin errors++; $display("FAIL b2b_busy_len2 got %0d want %0d", n, W); end
    e = exp_q.pop_front();
    hi = 1'b0; #1;
    checks++; if (bus !== e.lo) begin errors++; $display("FAIL b2b_lo2 got %h want %h", bus, e.lo); end
    hi = 1'b1; #1;
    checks++; if (bus !== e.hi) begin errors++; $display("FAIL b2b_hi2 got %h want %h", bus, e.hi); end
    hi = 1'b0;
    cycle();
  endtask

  task automatic test_clr_abort();
    exp_t e;
    int dn;
    op = 3'd0; a = 8'h7F; b = 8'h01; fi = 1'b1;
    e = model_alu(3'd0, 8'h7F, 8'h01, m_fl[3]);
    cycle();
    fi = 1'b0; m_fl = e.fl;
    op = 3'd7; a = 8'hFF; b = 8'hFF; go = 1'b1;
    cycle();
    go = 1'b0;
    cycle(); cycle(); cycle();
    #3;
    clr = 1'b1;
    #1;
    m_fl = 4'b0000;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
    checks++; if ({carry, zero, neg, ovf} !== m_fl) begin
      errors++; $display("FAIL clr_flags got %b want %b", {carry, zero, neg, ovf}, m_fl); end
    out = 1'b1; hi = 1'b0; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL clr_lo got %h want 00", bus); end
    hi = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL clr_hi got %h want 00", bus); end
    hi = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL clr_no_done got %0d busy/done cycles want 0", dn); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_cycle();
    test_bus_release();
    test_mul(8'hFF, 8'hFF);
    test_mul(8'h00, 8'hA5);
    test_mul(8'($urandom), 8'($urandom));
    test_interlock();
    test_back_to_back();
    test_clr_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
